// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS link sequencer: DVI control tokens,
// the clock-lane word and the sequencer state encoding.
package tmds_pkg;

  localparam logic [9:0] TOK_00    = 10'b1101010100;
  localparam logic [9:0] TOK_01    = 10'b0010101011;
  localparam logic [9:0] TOK_10    = 10'b0101010100;
  localparam logic [9:0] TOK_11    = 10'b1010101011;
  localparam logic [9:0] CLK_WORD  = 10'b0000011111;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ARM    = 2'd2,
    ST_RUN    = 2'd3
  } link_state_e;

  // Token selection is indexed by {vsync, hsync}.
  function automatic logic [9:0] ctl_token(input logic vs, input logic hs);
    logic [9:0] tok;
    case ({vs, hs})
      2'b00:   tok = TOK_00;
      2'b01:   tok = TOK_01;
      2'b10:   tok = TOK_10;
      default: tok = TOK_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_sync_dly.sv
// LAT-deep shift register that lines raw timing signals up with the encoder
// pipeline; a plain wire when LAT is zero.
module tmds_sync_dly #(
  parameter int LAT = 2,
  parameter int W   = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (LAT == 0) begin : g_pass
      assign q_o = d_i;
    end else begin : g_dly
      logic [W-1:0] taps_q [LAT];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < LAT; i++) taps_q[i] <= '0;
        end else begin
          taps_q[0] <= d_i;
          for (int i = 1; i < LAT; i++) taps_q[i] <= taps_q[i-1];
        end
      end

      assign q_o = taps_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/tmds_link_seq.sv
// Link sequencer: resets the serializers after MMCM lock, lets them settle,
// then opens the video path on a VSYNC edge so the sink only sees whole frames.
module tmds_link_seq
  import tmds_pkg::*;
#(
  parameter int   RST_CYCLES    = 16,
  parameter int   SETTLE_CYCLES = 8,
  parameter int   ENC_LAT       = 2,
  parameter logic VSYNC_POL     = 1'b1
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       LOCKED,
  input  logic       HSYNC,
  input  logic       VSYNC,
  input  logic       VDE,
  input  logic [9:0] ENC0,
  input  logic [9:0] ENC1,
  input  logic [9:0] ENC2,
  output logic       SER_RST,
  output logic [9:0] D_CH0,
  output logic [9:0] D_CH1,
  output logic [9:0] D_CH2,
  output logic [9:0] D_CLK,
  output logic       LINK_UP,
  output logic [7:0] LOSS_CNT
);

  localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_q, loss_d;
  logic             vs_prev_q;
  logic             ser_rst_q, link_up_q;
  logic [9:0]       ch0_q, ch1_q, ch2_q, ch0_d, ch1_d, ch2_d;

  logic [2:0] dly_q;
  logic       hs_d, vs_d, de_d;
  logic       vs_edge, pass;

  tmds_sync_dly #(.LAT(ENC_LAT), .W(3)) u_dly (
    .clk_i (PCLK),
    .rst_i (RESET),
    .d_i   ({HSYNC, VSYNC, VDE}),
    .q_o   (dly_q)
  );

  assign {hs_d, vs_d, de_d} = dly_q;
  assign vs_edge = (vs_prev_q != VSYNC_POL) && (vs_d == VSYNC_POL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (!LOCKED) begin
          cnt_d = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ARM:  if (vs_edge) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    // Lock loss outranks every other transition, including the arming edge.
    if (state_q != ST_HOLD && !LOCKED) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end
  end

  always_comb begin
    loss_d = loss_q;
    if (state_q == ST_RUN && !LOCKED && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
  end

  // Lane words are chosen from the next state so a lock drop blanks the very next word.
  always_comb begin
    pass  = (state_d == ST_RUN) && de_d;
    ch0_d = ctl_token(vs_d, hs_d);
    ch1_d = TOK_00;
    ch2_d = TOK_00;
    if (state_d == ST_HOLD) ch0_d = TOK_00;
    if (pass) begin
      ch0_d = ENC0;
      ch1_d = ENC1;
      ch2_d = ENC2;
    end
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      loss_q    <= '0;
      vs_prev_q <= 1'b0;
      ser_rst_q <= 1'b1;
      link_up_q <= 1'b0;
      ch0_q     <= TOK_00;
      ch1_q     <= TOK_00;
      ch2_q     <= TOK_00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      vs_prev_q <= vs_d;
      ser_rst_q <= (state_d == ST_HOLD);
      link_up_q <= (state_d == ST_RUN);
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
      ch2_q     <= ch2_d;
    end
  end

  assign SER_RST  = ser_rst_q;
  assign LINK_UP  = link_up_q;
  assign LOSS_CNT = loss_q;
  assign D_CH0    = ch0_q;
  assign D_CH1    = ch1_q;
  assign D_CH2    = ch2_q;
  assign D_CLK    = CLK_WORD;

endmodule

// File: tb/tb_tmds_link_seq.sv
// Directed bench for tmds_link_seq: stimulus pushes cycle-tagged expectations,
// a negedge monitor compares each one when its cycle comes up.
module tb_tmds_link_seq;

  localparam int RST_C = 16;
  localparam int SET_C = 8;
  localparam int LAT   = 2;

  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] T01 = 10'h0AB;
  localparam logic [9:0] T10 = 10'h154;
  localparam logic [9:0] T11 = 10'h2AB;
  localparam logic [9:0] CLKW = 10'h01F;

  localparam int S_CH0 = 0, S_CH1 = 1, S_CH2 = 2, S_CLK = 3, S_RST = 4, S_LINK = 5, S_LOSS = 6;

  logic       clk = 1'b0;
  logic       reset, locked, hsync, vsync, vde;
  logic [9:0] enc0, enc1, enc2;
  logic       ser_rst, link_up;
  logic [9:0] d_ch0, d_ch1, d_ch2, d_clk;
  logic [7:0] loss_cnt;

  typedef struct {
    int         cyc;
    int         sig;
    logic [9:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  tmds_link_seq #(
    .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C), .ENC_LAT(LAT), .VSYNC_POL(1'b1)
  ) dut (
    .PCLK(clk), .RESET(reset), .LOCKED(locked),
    .HSYNC(hsync), .VSYNC(vsync), .VDE(vde),
    .ENC0(enc0), .ENC1(enc1), .ENC2(enc2),
    .SER_RST(ser_rst), .D_CH0(d_ch0), .D_CH1(d_ch1), .D_CH2(d_ch2),
    .D_CLK(d_clk), .LINK_UP(link_up), .LOSS_CNT(loss_cnt)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      S_CH0:   return "D_CH0";
      S_CH1:   return "D_CH1";
      S_CH2:   return "D_CH2";
      S_CLK:   return "D_CLK";
      S_RST:   return "SER_RST";
      S_LINK:  return "LINK_UP";
      default: return "LOSS_CNT";
    endcase
  endfunction

  function automatic logic [9:0] sig_val(input int s);
    case (s)
      S_CH0:   return d_ch0;
      S_CH1:   return d_ch1;
      S_CH2:   return d_ch2;
      S_CLK:   return d_clk;
      S_RST:   return {9'd0, ser_rst};
      S_LINK:  return {9'd0, link_up};
      default: return {2'd0, loss_cnt};
    endcase
  endfunction

  // Driver tasks
  task automatic exp_at(input int c, input int s, input logic [9:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_sync(input logic v, input logic h, input logic de);
    vsync = v;
    hsync = h;
    vde   = de;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        logic [9:0] act;
        act = sig_val(exp_q[i].sig);
        n_vec++;
        if (act !== exp_q[i].val) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", sig_name(exp_q[i].sig), cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  initial begin
    int s;
    reset = 1'b1; locked = 1'b0;
    set_sync(1'b0, 1'b0, 1'b0);
    enc0 = '0; enc1 = '0; enc2 = '0;

    // Reset state
    exp_at(1, S_RST, 10'd1);  exp_at(1, S_LINK, 10'd0); exp_at(1, S_LOSS, 10'd0);
    exp_at(1, S_CH0, T00);    exp_at(1, S_CH1, T00);    exp_at(1, S_CH2, T00);
    exp_at(1, S_CLK, CLKW);

    goto(3); reset = 1'b0;

    // Power-up: lock rises at cycle 4, active-video pattern already present
    goto(4);
    locked = 1'b1;
    set_sync(1'b0, 1'b1, 1'b1);
    enc0 = 10'h3FF; enc1 = 10'h155; enc2 = 10'h2AA;
    exp_at(15, S_CH0, T00);
    exp_at(19, S_RST, 10'd1);
    exp_at(20, S_RST, 10'd0);
    exp_at(22, S_CH0, T01);   exp_at(22, S_CH1, T00);
    exp_at(30, S_CH0, T01);   exp_at(30, S_CH2, T00); exp_at(30, S_LINK, 10'd0);

    // Arming VSYNC edge
    goto(32);
    set_sync(1'b1, 1'b0, 1'b0);
    exp_at(34, S_LINK, 10'd0);
    exp_at(35, S_LINK, 10'd1); exp_at(35, S_CH0, T10);

    // Token map in RUN
    goto(36); set_sync(1'b0, 1'b0, 1'b0); exp_at(39, S_CH0, T00);
    goto(37); set_sync(1'b0, 1'b1, 1'b0); exp_at(40, S_CH0, T01); exp_at(40, S_CH1, T00);
    goto(38); set_sync(1'b1, 1'b0, 1'b0); exp_at(41, S_CH0, T10);
    goto(39); set_sync(1'b1, 1'b1, 1'b0); exp_at(42, S_CH0, T11); exp_at(42, S_CH2, T00);

    // Data pass, ENC aligned LAT cycles behind VDE
    goto(40); set_sync(1'b0, 1'b0, 1'b1);
    goto(42); enc0 = 10'h155; enc1 = 10'h111; enc2 = 10'h222;
    exp_at(43, S_CH0, 10'h155); exp_at(43, S_CH1, 10'h111); exp_at(43, S_CH2, 10'h222);
    goto(43); enc0 = 10'h2AA; exp_at(44, S_CH0, 10'h2AA); exp_at(44, S_CLK, CLKW);
    goto(44); enc0 = 10'h3FF; vde = 1'b0; exp_at(45, S_CH0, 10'h3FF);
    goto(45); enc0 = 10'h000; exp_at(46, S_CH0, 10'h000);
    goto(46); enc0 = 10'h3C3; exp_at(47, S_CH0, T00);

    // Single-cycle lock drop in RUN, then full re-sequence
    goto(50); locked = 1'b0;
    exp_at(51, S_RST, 10'd1); exp_at(51, S_LINK, 10'd0);
    exp_at(51, S_LOSS, 10'd1); exp_at(51, S_CH0, T00);
    goto(51); locked = 1'b1;
    exp_at(66, S_RST, 10'd1); exp_at(67, S_RST, 10'd0);

    // Lock drop coincides with the arming VSYNC edge
    goto(76); vsync = 1'b1;
    exp_at(78, S_LINK, 10'd0);
    goto(78); locked = 1'b0;
    exp_at(79, S_LINK, 10'd0); exp_at(79, S_RST, 10'd1); exp_at(79, S_LOSS, 10'd1);
    exp_at(80, S_LINK, 10'd0);
    goto(79); locked = 1'b1;
    goto(80); vsync = 1'b0;

    // RESET while in SETTLE
    goto(96); reset = 1'b1;
    exp_at(97, S_RST, 10'd1); exp_at(97, S_LINK, 10'd0);
    exp_at(97, S_LOSS, 10'd0); exp_at(97, S_CH0, T00);
    goto(97); reset = 1'b0;
    exp_at(112, S_RST, 10'd1); exp_at(113, S_RST, 10'd0);
    goto(122); vsync = 1'b1;
    exp_at(124, S_LINK, 10'd0); exp_at(125, S_LINK, 10'd1);

    // Repeated lock loss, LOSS_CNT saturates at 255
    s = 130;
    for (int n = 1; n <= 300; n++) begin
      goto(s);
      locked = 1'b0; vsync = 1'b0;
      exp_at(s + 1, S_RST, 10'd1); exp_at(s + 1, S_LINK, 10'd0);
      exp_at(s + 1, S_LOSS, (n > 255) ? 10'd255 : 10'(n));
      goto(s + 1); locked = 1'b1;
      goto(s + 26); vsync = 1'b1;
      exp_at(s + 28, S_LINK, 10'd0);
      exp_at(s + 29, S_LINK, 10'd1); exp_at(s + 29, S_RST, 10'd0);
      s += 30;
    end

    goto(s + 5);
    if (exp_q.size() != 0) begin
      n_bad += exp_q.size();
      $display("FAIL unchecked_expectations count=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
